// File: rtl/alu_multibyte_addsub_seq.sv
// Multi-byte signed add/sub: one 8-bit ripple slice reused per cycle,
// LSB first, carry chained, result zeroed on signed overflow.
// Ports: clk, reset (sync, active-high); Start/Op/Cin/A/B request;
//        Ready (idle), Done (1-cycle pulse), Sum/Carry/Overflow result.
module alu_multibyte_addsub_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  Op,
  input  logic                  Cin,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  output logic                  Ready,
  output logic                  Done,
  output logic [8*NBYTES-1:0]   Sum,
  output logic                  Carry,
  output logic                  Overflow
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_n;

  logic [W-1:0]  a_q, b_q, part_q, part_n;
  logic [W-1:0]  sum_q;
  logic          op_q, cy_q;
  logic          carry_q, ovf_q;
  logic [IW-1:0] idx_q;

  logic [7:0]    a_b, b_b, s_b;
  logic          c7, c8, c;
  logic          last;

  assign last = (idx_q == IW'(NBYTES - 1));

  // Byte slice; subtract adds the inverted B byte (carry seeded with 1).
  always_comb begin
    a_b = a_q[idx_q*8 +: 8];
    b_b = b_q[idx_q*8 +: 8];
    if (op_q) b_b = ~b_b;
    s_b = '0;
    c7  = 1'b0;
    c   = cy_q;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) c7 = c;
      s_b[k] = a_b[k] ^ b_b[k] ^ c;
      c      = (a_b[k] & b_b[k]) | (c & (a_b[k] ^ b_b[k]));
    end
    c8 = c;
  end

  always_comb begin
    part_n = part_q;
    part_n[idx_q*8 +: 8] = s_b;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    Ready = (state_q == IDLE);
    Done  = (state_q == DONE);
  end

  // Results are written only on the RUN->DONE edge so they hold
  // through any later RUN until the next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      cy_q    <= 1'b0;
      idx_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= Op;
            cy_q  <= Op ? 1'b1 : Cin;
            idx_q <= '0;
          end
        end
        RUN: begin
          part_q <= part_n;
          cy_q   <= c8;
          idx_q  <= idx_q + 1'b1;
          if (last) begin
            sum_q   <= (c8 ^ c7) ? '0 : part_n;
            carry_q <= c8;
            ovf_q   <= c8 ^ c7;
          end
        end
        default: ;
      endcase
    end
  end

  assign Sum      = sum_q;
  assign Carry    = carry_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_multibyte_addsub_seq.sv
// Directed bench for alu_multibyte_addsub_seq at NBYTES=4.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_multibyte_addsub_seq;

  logic        clk = 1'b0;
  logic        reset, Start, Op, Cin;
  logic [31:0] A, B, Sum;
  logic        Ready, Done, Carry, Overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        op;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        c;
    logic        v;
  } vec_t;

  always #5 clk = ~clk;

  alu_multibyte_addsub_seq #(.NBYTES(4)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .Cin(Cin),
    .A(A), .B(B), .Ready(Ready), .Done(Done), .Sum(Sum),
    .Carry(Carry), .Overflow(Overflow)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !Ready; i++) step();
    checks++;
    if (Ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: Ready=%b required 1 within 20 cycles", Ready);
    end
  endtask

  // Presents Start for one edge; returns 1ns after the accepting edge.
  task automatic do_start(input logic op, input logic cin,
                          input logic [31:0] a, input logic [31:0] b);
    Op = op; Cin = cin; A = a; B = b; Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  // n counts edges from the accepting edge to the first Done cycle.
  task automatic wait_done(output int n);
    n = 1;
    for (int i = 0; i < 20 && !Done; i++) begin
      step();
      n++;
    end
    if (!Done) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; Op = 1'b0; Cin = 1'b0;
    A = '0; B = '0;
    step(); step();
    reset = 1'b0;
    checks++;
    if (Ready !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: Ready=%b Done=%b required 1 0", Ready, Done);
    end
    checks++;
    if (Sum !== 32'h0 || Carry !== 1'b0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_res: Sum=%h C=%b V=%b required 0 0 0",
               Sum, Carry, Overflow);
    end
  endtask

  task automatic test_addsub();
    vec_t v [5];
    int   n;
    v[0] = '{1'b0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0};
    v[1] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
    v[2] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    v[3] = '{1'b1, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
    v[4] = '{1'b1, 1'b1, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      wait_ready();
      do_start(v[i].op, v[i].cin, v[i].a, v[i].b);
      checks++;
      if (Ready !== 1'b0) begin
        errors++;
        $display("FAIL addsub%0d_ready_drop: Ready=%b required 0", i, Ready);
      end
      wait_done(n);
      checks++;
      if (n != 5) begin
        errors++;
        $display("FAIL addsub%0d_latency: cycles=%0d required 5", i, n);
      end
      checks++;
      if (Sum !== v[i].s || Carry !== v[i].c || Overflow !== v[i].v) begin
        errors++;
        $display("FAIL addsub%0d_result: Sum=%h C=%b V=%b required %h %b %b",
                 i, Sum, Carry, Overflow, v[i].s, v[i].c, v[i].v);
      end
      step();
      checks++;
      if (Done !== 1'b0 || Ready !== 1'b1) begin
        errors++;
        $display("FAIL addsub%0d_after: Done=%b Ready=%b required 0 1",
                 i, Done, Ready);
      end
    end
  endtask

  task automatic test_start_ignored();
    int n, dones;
    wait_ready();
    do_start(1'b0, 1'b0, 32'h12345678, 32'h11111111);
    step();
    Start = 1'b1; Op = 1'b1; Cin = 1'b1;
    A = 32'hFFFFFFFF; B = 32'h00000001;
    step();
    Start = 1'b0;
    n = 3;
    for (int i = 0; i < 20 && !Done; i++) begin
      step();
      n++;
    end
    if (!Done) n = -1;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL ign_latency: cycles=%0d required 5", n);
    end
    checks++;
    if (Sum !== 32'h23456789 || Carry !== 1'b0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL ign_result: Sum=%h C=%b V=%b required 23456789 0 0",
               Sum, Carry, Overflow);
    end
    step();
    checks++;
    if (Ready !== 1'b1) begin
      errors++;
      $display("FAIL ign_ready: Ready=%b required 1", Ready);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (Done) dones++;
      step();
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL ign_extra_done: pulses=%0d required 0", dones);
    end
  endtask

  task automatic test_reset_mid_run();
    int n, dones;
    wait_ready();
    do_start(1'b0, 1'b0, 32'h00000001, 32'h00000001);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (Ready !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_ctl: Ready=%b Done=%b required 1 0", Ready, Done);
    end
    checks++;
    if (Sum !== 32'h0 || Carry !== 1'b0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_res: Sum=%h C=%b V=%b required 0 0 0",
               Sum, Carry, Overflow);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (Done) dones++;
      step();
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rst_run_done: pulses=%0d required 0", dones);
    end
    do_start(1'b0, 1'b0, 32'h00010000, 32'h0000FFFF);
    wait_done(n);
    checks++;
    if (n != 5 || Sum !== 32'h0001FFFF || Carry !== 1'b0 || Overflow !== 1'b0)
    begin
      errors++;
      $display("FAIL rst_run_after: cycles=%0d Sum=%h C=%b V=%b required 5 0001ffff 0 0",
               n, Sum, Carry, Overflow);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n, held_bad;
    wait_ready();
    do_start(1'b0, 1'b0, 32'h00000001, 32'h00000002);
    wait_done(n);
    checks++;
    if (n != 5 || Sum !== 32'h00000003) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d Sum=%h required 5 00000003", n, Sum);
    end
    step();
    checks++;
    if (Ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: Ready=%b required 1", Ready);
    end
    do_start(1'b1, 1'b0, 32'h0000000A, 32'h00000003);
    n = 1;
    held_bad = 0;
    for (int i = 0; i < 20 && !Done; i++) begin
      checks++;
      if (Sum !== 32'h00000003) begin
        errors++;
        held_bad++;
        $display("FAIL b2b_hold: Sum=%h required 00000003", Sum);
      end
      step();
      n++;
    end
    if (!Done) n = -1;
    checks++;
    if (n != 5 || Sum !== 32'h00000007 || Carry !== 1'b1 || Overflow !== 1'b0)
    begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d Sum=%h C=%b V=%b required 5 00000007 1 0",
               n, Sum, Carry, Overflow);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
